// File: rtl/video_capture_pkg.sv
// rtl/video_capture_pkg.sv - shared types, register map and state encoding for the capture tap
package video_capture_pkg;

   typedef struct packed {
      logic [10:0] hc;
      logic [10:0] vc;
   } vga_fc_t;

   localparam logic [31:0] REG_CTRL     = 32'h0000_0000;
   localparam logic [31:0] REG_XORG     = 32'h0000_0004;
   localparam logic [31:0] REG_YORG     = 32'h0000_0008;
   localparam logic [31:0] REG_RAM_BASE = 32'h0000_0010;

   localparam int CTRL_ARM   = 0;
   localparam int CTRL_ABORT = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } cap_state_t;

endpackage

// File: rtl/video_capture_ram.sv
// rtl/video_capture_ram.sv - capture RAM, one write port and one registered read port
module video_capture_ram #(
   parameter int DW = 12,
   parameter int AW = 10
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rdata_q;

   // Read samples the array before this edge's write, so a colliding read sees old data.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/video_capture_core.sv
// rtl/video_capture_core.sv - pixel passthrough with armed one-frame window capture, Avalon-MM readback
module video_capture_core
   import video_capture_pkg::*;
#(
   parameter int RGB_SIZE   = 12,
   parameter int CAP_HSIZE  = 32,
   parameter int CAP_VSIZE  = 32,
   parameter int CAP_RAM_AW = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  avs_write,
   input  logic                  avs_read,
   input  logic [CAP_RAM_AW:0]   avs_address,
   input  logic [31:0]           avs_writedata,
   output logic [31:0]           avs_readdata,
   output logic                  avs_readdatavalid,
   input  logic                  src_vld,
   output logic                  src_rdy,
   input  vga_fc_t               src_fc,
   input  logic [RGB_SIZE-1:0]   src_rgb,
   input  logic                  snk_rdy,
   output logic                  snk_vld,
   output vga_fc_t               snk_fc,
   output logic [RGB_SIZE-1:0]   snk_rgb
);

   logic                  snk_vld_q;
   vga_fc_t               snk_fc_q;
   logic [RGB_SIZE-1:0]   snk_rgb_q;
   logic [31:0]           x_origin_q, y_origin_q;
   cap_state_t            state_q, state_d;
   logic                  done_q, done_d;
   logic                  rvalid_q, ram_sel_q;
   logic [31:0]           reg_rdata_q;
   logic [RGB_SIZE-1:0]   ram_rdata;
   logic                  ram_we;

   logic                  accept, busy, frame_start, in_win, last_px;
   logic                  is_ram_addr, wr_ctrl, arm, abort;
   logic [31:0]           addr32, dx, dy;
   logic [CAP_RAM_AW-1:0] waddr;

   assign src_rdy = snk_rdy | ~snk_vld_q;
   assign accept  = src_vld & src_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         snk_vld_q <= 1'b0;
         snk_fc_q  <= '0;
         snk_rgb_q <= '0;
      end else if (accept) begin
         snk_vld_q <= 1'b1;
         snk_fc_q  <= src_fc;
         snk_rgb_q <= src_rgb;
      end else if (snk_rdy) begin
         snk_vld_q <= 1'b0;
      end
   end

   assign snk_vld = snk_vld_q;
   assign snk_fc  = snk_fc_q;
   assign snk_rgb = snk_rgb_q;

   assign addr32      = 32'(avs_address);
   assign is_ram_addr = addr32 >= REG_RAM_BASE;
   assign wr_ctrl     = avs_write && (addr32 == REG_CTRL);
   assign arm         = wr_ctrl && avs_writedata[CTRL_ARM];
   assign abort       = wr_ctrl && avs_writedata[CTRL_ABORT];

   always_ff @(posedge clk) begin
      if (rst) begin
         x_origin_q <= '0;
         y_origin_q <= '0;
      end else if (avs_write) begin
         if (addr32 == REG_XORG) x_origin_q <= avs_writedata;
         if (addr32 == REG_YORG) y_origin_q <= avs_writedata;
      end
   end

   // Unsigned wrap pushes beats left of / above the origin far outside the window.
   assign dx          = 32'(src_fc.hc) - x_origin_q;
   assign dy          = 32'(src_fc.vc) - y_origin_q;
   assign in_win      = (dx < 32'(CAP_HSIZE)) && (dy < 32'(CAP_VSIZE));
   assign last_px     = (dx == 32'(CAP_HSIZE - 1)) && (dy == 32'(CAP_VSIZE - 1));
   assign frame_start = (src_fc.hc == '0) && (src_fc.vc == '0);
   assign waddr       = CAP_RAM_AW'(dy * 32'(CAP_HSIZE) + dx);
   assign busy        = (state_q == ARMED) || (state_q == CAPTURE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      done_d  = done_q;
      ram_we  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (arm) begin
               state_d = ARMED;
               done_d  = 1'b0;
            end
         end
         ARMED: begin
            if (accept && frame_start) begin
               state_d = CAPTURE;
               ram_we  = in_win;
               if (in_win && last_px) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         CAPTURE: begin
            if (accept) begin
               if (frame_start) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else if (in_win) begin
                  ram_we = 1'b1;
                  if (last_px) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Abort overrides arm and any in-flight capture write; done keeps its value.
      if (abort) begin
         state_d = IDLE;
         done_d  = done_q;
         ram_we  = 1'b0;
      end
   end

   video_capture_ram #(
      .DW (RGB_SIZE),
      .AW (CAP_RAM_AW)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (waddr),
      .wdata_i (src_rgb),
      .re_i    (avs_read && is_ram_addr),
      .raddr_i (avs_address[CAP_RAM_AW:1]),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q    <= 1'b0;
         ram_sel_q   <= 1'b0;
         reg_rdata_q <= '0;
      end else begin
         rvalid_q <= avs_read;
         if (avs_read) begin
            ram_sel_q <= is_ram_addr;
            case (addr32)
               REG_CTRL: reg_rdata_q <= {30'b0, done_q, busy};
               REG_XORG: reg_rdata_q <= x_origin_q;
               REG_YORG: reg_rdata_q <= y_origin_q;
               default:  reg_rdata_q <= '0;
            endcase
         end
      end
   end

   assign avs_readdata      = ram_sel_q ? 32'(ram_rdata) : reg_rdata_q;
   assign avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_video_capture_core.sv
// tb/tb_video_capture_core.sv - directed self-checking bench for video_capture_core
module tb_video_capture_core;
   import video_capture_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        avs_write = 1'b0, avs_read = 1'b0;
   logic [10:0] avs_address = '0;
   logic [31:0] avs_writedata = '0;
   logic [31:0] avs_readdata;
   logic        avs_readdatavalid;
   logic        src_vld = 1'b0, src_rdy;
   vga_fc_t     src_fc = '0;
   logic [11:0] src_rgb = '0;
   logic        snk_rdy = 1'b1, snk_vld;
   vga_fc_t     snk_fc;
   logic [11:0] snk_rgb;

   video_capture_core dut (
      .clk(clk), .rst(rst),
      .avs_write(avs_write), .avs_read(avs_read), .avs_address(avs_address),
      .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
      .avs_readdatavalid(avs_readdatavalid),
      .src_vld(src_vld), .src_rdy(src_rdy), .src_fc(src_fc), .src_rgb(src_rgb),
      .snk_rdy(snk_rdy), .snk_vld(snk_vld), .snk_fc(snk_fc), .snk_rgb(snk_rgb)
   );

   always #5 clk = ~clk;

   typedef struct { int h; int v; logic [11:0] rgb; } beat_t;
   beat_t exp_q[$];

   int n_chk = 0, n_fail = 0;
   int mism = 0, pushed = 0, popped = 0;
   int cyc = 0, stall_end = 0, we_cnt = 0;
   bit rand_mode = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sink ready: random, or held low until stall_end; changed just after posedge.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (rand_mode) snk_rdy = 1'($urandom_range(0, 1));
      else           snk_rdy = (cyc >= stall_end);
   end

   always @(negedge clk) begin
      if (dut.ram_we) we_cnt++;
      if (snk_vld && snk_rdy) begin
         if (exp_q.size() == 0) mism++;
         else begin
            beat_t b;
            b = exp_q.pop_front();
            if (snk_fc.hc != 11'(b.h) || snk_fc.vc != 11'(b.v) || snk_rgb != b.rgb) mism++;
         end
         popped++;
      end
      if (rst) exp_q.delete();
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1);
   end

   task automatic send(input int h, input int v, input logic [11:0] rgb);
      int n = 0;
      src_vld = 1'b1; src_fc.hc = 11'(h); src_fc.vc = 11'(v); src_rgb = rgb;
      while (!src_rdy && n < 200) begin @(negedge clk); n++; end
      if (!src_rdy) check_eq("send_rdy", 32'(src_rdy), 32'd1);
      else begin exp_q.push_back('{h, v, rgb}); pushed++; end
      @(negedge clk);
      src_vld = 1'b0;
   endtask

   task automatic stream_rect(input int x_lo, input int x_hi, input int y_lo, input int y_hi, input int key);
      for (int v = y_lo; v <= y_hi; v++)
         for (int h = x_lo; h <= x_hi; h++)
            send(h, v, 12'(h ^ v ^ key));
   endtask

   task automatic avs_wr(input int addr, input logic [31:0] d);
      avs_write = 1'b1; avs_address = 11'(addr); avs_writedata = d;
      @(negedge clk);
      avs_write = 1'b0;
   endtask

   task automatic avs_rd(input int addr, output logic [31:0] d);
      avs_read = 1'b1; avs_address = 11'(addr);
      @(negedge clk);
      avs_read = 1'b0;
      check_eq("rdv_pulse", 32'(avs_readdatavalid), 32'd1);
      d = avs_readdata;
      @(negedge clk);
      check_eq("rdv_clear", 32'(avs_readdatavalid), 32'd0);
   endtask

   task automatic rd_chk(input string tag, input int addr, input logic [31:0] exp);
      logic [31:0] d;
      avs_rd(addr, d);
      check_eq(tag, d, exp);
   endtask

   initial begin
      logic [31:0] d;
      int errs, we0;

      repeat (3) @(negedge clk);
      check_eq("rst_snk_vld", 32'(snk_vld), 32'd0);
      check_eq("rst_snk_rgb", 32'(snk_rgb), 32'd0);
      check_eq("rst_readdata", avs_readdata, 32'd0);
      check_eq("rst_rdv", 32'(avs_readdatavalid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      rd_chk("rst_status", 'h0, 32'h0);
      rd_chk("rst_xorg", 'h4, 32'h0);
      rd_chk("rst_yorg", 'h8, 32'h0);
      rd_chk("reg_0c", 'hC, 32'h0);

      send(5, 7, 12'hABC);
      check_eq("lat_vld", 32'(snk_vld), 32'd1);
      check_eq("lat_rgb", 32'(snk_rgb), 32'hABC);
      check_eq("lat_hc", 32'(snk_fc.hc), 32'd5);
      @(negedge clk);
      check_eq("lat_drain", 32'(snk_vld), 32'd0);

      rand_mode = 1;
      for (int i = 0; i < 300; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send($urandom_range(1, 639), $urandom_range(0, 479), 12'($urandom));
      end
      rand_mode = 0;
      repeat (4) @(negedge clk);
      check_eq("pass_mismatch", 32'(mism), 32'd0);
      check_eq("pass_count", 32'(popped), 32'(pushed));

      avs_wr('h0, 32'h1);
      rd_chk("ctl_armed", 'h0, 32'h1);
      avs_wr('h0, 32'h2);
      rd_chk("ctl_abort", 'h0, 32'h0);
      avs_wr('h0, 32'h3);
      rd_chk("ctl_arm_abort", 'h0, 32'h0);
      avs_wr('h0, 32'h1);
      send(0, 0, 12'h000);
      avs_wr('h0, 32'h1);
      check_eq("ctl_arm_in_cap", 32'(dut.state_q), 32'(CAPTURE));
      avs_wr('h0, 32'h2);
      rd_chk("ctl_cap_abort", 'h0, 32'h0);

      avs_wr('h4, 32'd100);
      avs_wr('h8, 32'd50);
      avs_wr('h20, 32'hFFFF);
      rd_chk("xorg_rb", 'h4, 32'd100);
      rd_chk("yorg_rb", 'h8, 32'd50);

      avs_wr('h0, 32'h1);
      send(0, 0, 12'h000);
      stream_rect(96, 135, 48, 80, 0);
      stream_rect(96, 130, 81, 81, 0);
      rd_chk("cap_busy_before_last", 'h0, 32'h1);
      send(131, 81, 12'(131 ^ 81));
      rd_chk("cap_done", 'h0, 32'h2);
      stream_rect(132, 135, 81, 81, 0);
      stream_rect(96, 135, 82, 83, 0);
      check_eq("cap_ram0", 32'(dut.u_ram.mem_q[0]), 32'(100 ^ 50));
      rd_chk("cap_ram33", 2 * 33, 32'(101 ^ 51));
      rd_chk("cap_ram1023", 2 * 1023, 32'(131 ^ 81));

      avs_wr('h4, 32'd630);
      avs_wr('h8, 32'd470);
      avs_wr('h0, 32'h1);
      send(0, 0, 12'h000);
      stream_rect(620, 639, 468, 479, 0);
      rd_chk("clip_busy", 'h0, 32'h1);
      send(0, 0, 12'hFFF);
      rd_chk("clip_done", 'h0, 32'h2);
      check_eq("clip_ram0", 32'(dut.u_ram.mem_q[0]), 32'(630 ^ 470));
      rd_chk("clip_ram9", 2 * 9, 32'(639 ^ 470));
      rd_chk("clip_ram32", 2 * 32, 32'(630 ^ 471));
      rd_chk("clip_ram297", 2 * 297, 32'(639 ^ 479));
      rd_chk("clip_keep10", 2 * 10, 32'(110 ^ 50));
      rd_chk("clip_keep320", 2 * 320, 32'(100 ^ 60));
      avs_wr('h0, 32'h2);
      rd_chk("abort_keeps_done", 'h0, 32'h2);

      avs_wr('h4, 32'd100);
      avs_wr('h8, 32'd50);
      we0 = we_cnt;
      avs_wr('h0, 32'h1);
      send(0, 0, 12'h000);
      stream_rect(96, 135, 48, 59, 'hA5A);
      stall_end = cyc + 20;
      stream_rect(96, 135, 60, 83, 'hA5A);
      rd_chk("bp_done", 'h0, 32'h2);
      check_eq("bp_writes", 32'(we_cnt - we0), 32'd1024);
      errs = 0;
      for (int i = 0; i < 1024; i++)
         if (dut.u_ram.mem_q[i] !== 12'((100 + i % 32) ^ (50 + i / 32) ^ 'hA5A)) errs++;
      check_eq("bp_ram_all", 32'(errs), 32'd0);

      avs_wr('h0, 32'h1);
      send(0, 0, 12'h000);
      stream_rect(96, 135, 48, 50, 'h111);
      check_eq("rst_mid_vld_pre", 32'(snk_vld), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("rst_mid_vld", 32'(snk_vld), 32'd0);
      rd_chk("rst_mid_status", 'h0, 32'h0);
      avs_wr('h0, 32'h1);
      send(0, 0, 12'h333);
      stream_rect(1, 31, 0, 0, 'h333);
      stream_rect(0, 31, 1, 31, 'h333);
      rd_chk("rearm_done", 'h0, 32'h2);
      check_eq("rearm_ram0", 32'(dut.u_ram.mem_q[0]), 32'h333);
      rd_chk("rearm_ram37", 2 * 37, 32'(5 ^ 1 ^ 'h333));
      rd_chk("rearm_ram1023", 2 * 1023, 32'h333);

      repeat (4) @(negedge clk);
      check_eq("stream_mismatch", 32'(mism), 32'd0);
      check_eq("stream_left", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
